// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register address, data word and writeback source.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_REG = 32;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bitmap: set on issue, cleared on register-file writeback,
// with a sticky error flag for a writeback to a register that was not busy.
module wb_scoreboard
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iss_valid_i,
  input  reg_addr_t          iss_rd_i,
  input  logic               wb_we_i,
  input  reg_addr_t          wb_rd_i,
  output logic [NUM_REG-1:0] pending_o,
  output logic               sb_err_o
);

  logic [NUM_REG-1:0] pending_d, pending_q;
  logic               sb_err_d, sb_err_q;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pending_d = pending_q;
    sb_err_d  = sb_err_q;
    if (wb_we_i) begin
      pending_d[wb_rd_i] = 1'b0;
      if (!pending_q[wb_rd_i]) sb_err_d = 1'b1;
    end
    // Issue is applied after the clear so a same-register set wins.
    if (iss_valid_i && (iss_rd_i != '0)) pending_d[iss_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // NOTE: the bitmap is only 32 flops, so it is reset like ordinary state
  // rather than treated as an unreset storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign pending_o = pending_q;
  assign sb_err_o  = sb_err_q;

endmodule

// File: rtl/regfile_wb_arb.sv
// Two-source (ALU/LSU) register-file writeback arbiter with LSU anti-starvation.
// Optional issue scoreboard compiled in with `define REGFILE_WB_ARB_SB_EN.
module regfile_wb_arb
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      alu_valid,
  input  reg_addr_t alu_rd,
  input  word_t     alu_data,
  output logic      alu_ready,
  input  logic      lsu_valid,
  input  reg_addr_t lsu_rd,
  input  word_t     lsu_data,
  output logic      lsu_ready,
  output logic      rf_we,
  output reg_addr_t rf_rd,
  output word_t     rf_wdata
`ifdef REGFILE_WB_ARB_SB_EN
  ,
  input  logic               iss_valid,
  input  reg_addr_t          iss_rd,
  output logic [NUM_REG-1:0] pending,
  output logic               sb_err
`endif
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
  wb_src_e          src_d, src_q;
  reg_addr_t        rf_rd_d, rf_rd_q;
  word_t            rf_wdata_d, rf_wdata_q;

  logic lsu_pri;
  logic grant_alu;
  logic grant_lsu;

  // LSU wins a contended cycle only once it has lost STARVE_LIMIT in a row.
  assign lsu_pri   = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign grant_lsu = lsu_valid && (!alu_valid || lsu_pri);
  assign grant_alu = alu_valid && !grant_lsu;

  // The write port never stalls, so ready is purely the arbitration result.
  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  always_comb begin
    starve_cnt_d = '0;
    src_d        = WB_NONE;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    if (lsu_valid && !grant_lsu) starve_cnt_d = starve_cnt_q + 1'b1;
    if (grant_alu) begin
      src_d      = WB_ALU;
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
    end else if (grant_lsu) begin
      src_d      = WB_LSU;
      rf_rd_d    = lsu_rd;
      rf_wdata_d = lsu_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      src_q        <= WB_NONE;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      src_q        <= src_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  // Writes to x0 are accepted upstream but never reach the register file.
  assign rf_we    = (src_q != WB_NONE) && (rf_rd_q != '0);
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

`ifdef REGFILE_WB_ARB_SB_EN
  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .wb_we_i     (rf_we),
    .wb_rd_i     (rf_rd),
    .pending_o   (pending),
    .sb_err_o    (sb_err)
  );
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed self-checking bench for regfile_wb_arb; scoreboard scenarios run
// when REGFILE_WB_ARB_SB_EN is defined.
module tb_regfile_wb_arb;
  import riscv_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      alu_valid;
  reg_addr_t alu_rd;
  word_t     alu_data;
  logic      alu_ready;
  logic      lsu_valid;
  reg_addr_t lsu_rd;
  word_t     lsu_data;
  logic      lsu_ready;
  logic      rf_we;
  reg_addr_t rf_rd;
  word_t     rf_wdata;
`ifdef REGFILE_WB_ARB_SB_EN
  logic        iss_valid;
  reg_addr_t   iss_rd;
  logic [31:0] pending;
  logic        sb_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arb #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata)
`ifdef REGFILE_WB_ARB_SB_EN
    ,
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .pending   (pending),
    .sb_err    (sb_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; registered outputs are read there too.
  task automatic drive(input logic av, input reg_addr_t ar, input word_t ad,
                       input logic lv, input reg_addr_t lr, input word_t ld);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #3;
    n_checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b rd=%0d data=%h, want 0/0/0", rf_we, rf_rd, rf_wdata);
    end
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, '0);
    #1;
    n_checks++;
    if (alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_comb: got alu_ready=%b, want 1", alu_ready);
    end
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_no_register: got we=%b rd=%0d, want 0/0", rf_we, rf_rd);
    end
    rst_n = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_alu_single();
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0);
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_single_ready: got alu=%b lsu=%b, want 1/0", alu_ready, lsu_ready);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h1234) begin
      n_fail++;
      $display("FAIL alu_single_write: got we=%b rd=%0d data=%h, want 1/5/00001234", rf_we, rf_rd, rf_wdata);
    end
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_single_idle: got we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_lone_lsu();
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd12, 32'hCAFE_0012);
    #1;
    n_checks++;
    if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lone_lsu_ready: got alu=%b lsu=%b, want 0/1", alu_ready, lsu_ready);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd12 || rf_wdata !== 32'hCAFE_0012) begin
      n_fail++;
      $display("FAIL lone_lsu_write: got we=%b rd=%0d data=%h, want 1/12/cafe0012", rf_we, rf_rd, rf_wdata);
    end
  endtask

  // Both valid for 8 cycles: ALU x4, LSU on cycle 5, then ALU again.
  task automatic test_starvation();
    logic      exp_lsu;
    logic      prev_lsu;
    reg_addr_t exp_rd;
    word_t     exp_data;
    prev_lsu = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c > 1) begin
        exp_rd   = prev_lsu ? 5'd2 : 5'd1;
        exp_data = prev_lsu ? 32'hBBBB_0002 : 32'hAAAA_0001;
        n_checks++;
        if (rf_we !== 1'b1 || rf_rd !== exp_rd || rf_wdata !== exp_data) begin
          n_fail++;
          $display("FAIL starve_write_c%0d: got we=%b rd=%0d data=%h, want 1/%0d/%h",
                   c - 1, rf_we, rf_rd, rf_wdata, exp_rd, exp_data);
        end
      end
      if (c == 9) begin
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      end else begin
        drive(1'b1, 5'd1, 32'hAAAA_0001, 1'b1, 5'd2, 32'hBBBB_0002);
        exp_lsu = (c == 5);
        #1;
        n_checks++;
        if (lsu_ready !== exp_lsu || alu_ready !== !exp_lsu) begin
          n_fail++;
          $display("FAIL starve_grant_c%0d: got alu=%b lsu=%b, want %b/%b",
                   c, alu_ready, lsu_ready, !exp_lsu, exp_lsu);
        end
        prev_lsu = exp_lsu;
      end
    end
  endtask

  // A cycle with lsu_valid=0 clears the starvation count.
  task automatic test_starve_clear();
    logic av_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic lv_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic ls_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive(av_tab[c], 5'd3, 32'h0000_0033, lv_tab[c], 5'd4, 32'h0000_0044);
      #1;
      n_checks++;
      if (lsu_ready !== ls_tab[c] || alu_ready !== !ls_tab[c]) begin
        n_fail++;
        $display("FAIL starve_clear_c%0d: got alu=%b lsu=%b, want %b/%b",
                 c, alu_ready, lsu_ready, !ls_tab[c], ls_tab[c]);
      end
    end
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    n_checks++;
    if (lsu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_zero_ready: got lsu=%b, want 1", lsu_ready);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_zero_we: got we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 5'd10, 32'h0000_AAAA, 1'b0, 5'd0, '0);
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd11, 32'h0000_BBBB);
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'h0000_AAAA) begin
      n_fail++;
      $display("FAIL b2b_first: got we=%b rd=%0d data=%h, want 1/10/0000aaaa", rf_we, rf_rd, rf_wdata);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd11 || rf_wdata !== 32'h0000_BBBB) begin
      n_fail++;
      $display("FAIL b2b_second: got we=%b rd=%0d data=%h, want 1/11/0000bbbb", rf_we, rf_rd, rf_wdata);
    end
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 5'd6, 32'h0000_0066, 1'b0, 5'd0, '0);
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd6) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got we=%b rd=%0d, want 1/6", rf_we, rf_rd);
    end
    rst_n = 1'b0;
    drive(1'b1, 5'd8, 32'h0000_0088, 1'b0, 5'd0, '0);
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_immediate: got we=%b rd=%0d data=%h, want 0/0/0", rf_we, rf_rd, rf_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (rf_we !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_after_c%0d: got we=%b, want 0", c, rf_we);
      end
    end
  endtask

`ifdef REGFILE_WB_ARB_SB_EN
  task automatic test_scoreboard();
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7;
    @(negedge clk);
    iss_valid = 1'b0; iss_rd = 5'd0;
    n_checks++;
    if (pending[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_issue7: got pending[7]=%b, want 1", pending[7]);
    end
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, '0);
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    @(negedge clk);
    n_checks++;
    if (pending[7] !== 1'b0 || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_commit7: got pending[7]=%b err=%b, want 0/0", pending[7], sb_err);
    end
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, '0);
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    @(negedge clk);
    n_checks++;
    if (sb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_err_set: got err=%b, want 1", sb_err);
    end
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, '0);
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd0;
    n_checks++;
    if (pending[3] !== 1'b1 || sb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set_wins: got pending[3]=%b err=%b, want 1/1", pending[3], sb_err);
    end
    @(negedge clk);
    iss_valid = 1'b0;
    n_checks++;
    if (pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_x0: got pending[0]=%b, want 0", pending[0]);
    end
  endtask
`endif

  initial begin
`ifdef REGFILE_WB_ARB_SB_EN
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
`endif
    test_reset();
    test_alu_single();
    test_lone_lsu();
    test_starvation();
    test_starve_clear();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef REGFILE_WB_ARB_SB_EN
    test_scoreboard();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive cycles the LSU source may lose arbitration while valid.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-004 SHALL have port alu_valid, input, 1, meaning the ALU writeback request.
REQ-005 SHALL have port alu_rd, input, reg_addr_t, meaning the ALU destination register.
REQ-006 SHALL have port alu_data, input, word_t, meaning the ALU result.
REQ-007 SHALL have port alu_ready, output, 1, meaning the ALU request is accepted this cycle.
REQ-008 SHALL have ports lsu_valid, lsu_rd, lsu_data and lsu_ready with the same widths and meanings for the load unit.
REQ-009 SHALL have port rf_we, output, 1, meaning the register-file write enable.
REQ-010 SHALL have port rf_rd, output, reg_addr_t, meaning the register-file write address.
REQ-011 SHALL have port rf_wdata, output, word_t, meaning the register-file write data.
REQ-012 SHALL, when SB_EN is defined, add these ports: iss_valid (input, 1), iss_rd (input, reg_addr_t), pending (output, 32, per-register busy bitmap), sb_err (output, 1, sticky).

Function
REQ-013 SHALL generate grants combinationally, at most one per cycle: valid AND ready completes the handshake.
REQ-014 SHALL grant the ALU by default when both sources are valid.
REQ-015 SHALL count, in starve_cnt, the consecutive cycles in which lsu_valid=1 and the LSU is not granted; the count SHALL clear on any LSU grant or whenever lsu_valid=0.
REQ-016 SHALL grant the LSU over the ALU when starve_cnt equals STARVE_LIMIT.
REQ-017 SHALL grant a lone valid source in the same cycle, regardless of starve_cnt.
REQ-018 SHALL register the granted rd and data into the rf_* outputs with 1-cycle latency: a handshake at edge N makes rf_we=1 during cycle N+1.
REQ-019 SHALL drive rf_we=0 in any cycle that follows a cycle with no grant.
REQ-020 SHALL accept a granted request whose rd equals 0, but SHALL drive rf_we=0 for it (x0 is hardwired to zero).
REQ-021 SHALL keep the ready outputs independent of rf_we, since the register-file write port never stalls.

Scoreboard (SB_EN)
REQ-022 SHALL set pending[iss_rd] on iss_valid=1 when iss_rd is not 0.
REQ-023 SHALL clear pending[rf_rd] in a cycle where rf_we=1.
REQ-024 SHALL let the set win when a set and a clear target the same register in the same cycle.
REQ-025 SHALL hold pending[0] at 0 at all times.
REQ-026 SHALL set sb_err, and hold it until reset, when rf_we=1 and pending[rf_rd]=0 in the same cycle.

Reset
REQ-027 SHALL, while rst_n=0, immediately force rf_we=0, rf_rd=0, rf_wdata=0, starve_cnt=0, pending=0 and sb_err=0.
REQ-028 SHALL leave the ready outputs combinational during reset and SHALL not register any grant while rst_n=0.
REQ-029 SHALL cancel an in-flight registered write on reset mid-operation, with no write issued after rst_n rises.

Configuration
REQ-030 SHALL, with macro REGFILE_WB_ARB_SB_EN defined, compile in the scoreboard of REQ-022 to REQ-026 together with its ports.
REQ-031 SHALL, without REGFILE_WB_ARB_SB_EN, omit those ports and that logic and leave arbitration behaviour unchanged.

Structure
REQ-032 SHALL take reg_addr_t and word_t from riscv_pkg.
REQ-033 SHALL add to riscv_pkg the enum wb_src_e {WB_NONE, WB_ALU, WB_LSU}, used for the registered grant source.
REQ-034 SHALL implement the scoreboard as sub-module wb_scoreboard, instantiated only under the macro.

Verification
REQ-035 SHALL check: ALU only, rd=5, data=0x1234 -> alu_ready=1 in the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234.
REQ-036 SHALL check: both sources valid for 8 cycles, STARVE_LIMIT=4 -> ALU granted for 4 cycles, LSU granted in cycle 5, ALU granted again in cycle 6.
REQ-037 SHALL check: LSU rd=0, data=0xFFFFFFFF -> lsu_ready=1, rf_we stays 0.
REQ-038 SHALL check: rst_n asserted in the cycle after an ALU grant -> rf_we=0 immediately, and no write appears after reset release.
REQ-039 SHALL check (SB_EN): issue rd=7, then commit rd=7 -> pending[7] goes 1 then 0; then commit rd=9 with nothing issued -> sb_err=1.
REQ-040 SHALL check (SB_EN): iss_rd=3 in the same cycle as commit rd=3 -> pending[3]=1.
